// File: rtl/error_count_ctrl.sv
// Bit-error counter controlled by SPI command words. It counts DATA_IN/REF_IN
// mismatches over a window of valid bits and hands the result to the SPI transmitter.
module error_count_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CHIP_SELECT,
    input  logic [15:0] spi_control_reg,
    input  logic        DATA_IN,
    input  logic        REF_IN,
    input  logic        DATA_VALID,
    output logic [15:0] ERROR_COUNT_reg,
    output logic        READY_new_data_to_miso,
    output logic        BUSY,
    output logic        OVERFLOW
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [3:0] {
        OP_START = 4'h1,
        OP_STOP  = 4'h2,
        OP_CLEAR = 4'h3,
        OP_SNAP  = 4'h4
    } opcode_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_prev;
    logic                   cmd_strobe;
    logic [3:0]             opcode;
    logic [11:0]            argument;
    logic                   is_start, is_stop, is_clear, is_snap;
    logic                   mismatch;
    logic [15:0]            count, count_n;
    logic [11:0]            window, window_n;
    logic                   overflow_n;
    logic                   snap_load;
    logic [15:0]            snap_val;

    // Preset to 1 (idle-high CS) so that releasing reset produces no strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cs_sync <= '1;
            cs_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values; blocking here would collapse the chain.
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], CHIP_SELECT};
            cs_prev <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign cmd_strobe = cs_sync[SYNC_STAGES-1] & ~cs_prev;
    assign opcode     = spi_control_reg[15:12];
    assign argument   = spi_control_reg[11:0];
    assign is_start   = cmd_strobe && (opcode == OP_START);
    assign is_stop    = cmd_strobe && (opcode == OP_STOP);
    assign is_clear   = cmd_strobe && (opcode == OP_CLEAR);
    assign is_snap    = cmd_strobe && (opcode == OP_SNAP);
    assign mismatch   = DATA_VALID && (DATA_IN != REF_IN);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        state_n    = state;
        count_n    = count;
        window_n   = window;
        overflow_n = OVERFLOW;
        snap_load  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (state == ST_DONE) begin
                    state_n   = ST_IDLE;
                    snap_load = 1'b1;
                end
                if (is_start) begin
                    state_n    = ST_RUN;
                    count_n    = '0;
                    overflow_n = 1'b0;
                    window_n   = argument;
                end
            end
            ST_RUN: begin
                if (is_start) begin
                    count_n    = '0;
                    overflow_n = 1'b0;
                    window_n   = argument;
                end else begin
                    if (mismatch) begin
                        if (count == 16'hFFFF) overflow_n = 1'b1;
                        else                   count_n    = count + 16'd1;
                    end
                    // Window zero means free-running: only STOP ends the run.
                    if (DATA_VALID && (window != '0)) begin
                        window_n = window - 12'd1;
                        if (window == 12'd1) state_n = ST_DONE;
                    end
                    if (is_stop) state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (is_clear) begin
            count_n    = '0;
            overflow_n = 1'b0;
        end
        if (is_snap) snap_load = 1'b1;
        // A snapshot includes this cycle's mismatch; the DONE load takes the final count.
        snap_val = is_snap ? count_n : count;
        BUSY     = (state == ST_RUN);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state                  <= ST_IDLE;
            count                  <= '0;
            window                 <= '0;
            OVERFLOW               <= 1'b0;
            ERROR_COUNT_reg        <= '0;
            READY_new_data_to_miso <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            window   <= window_n;
            OVERFLOW <= overflow_n;
            if (snap_load) ERROR_COUNT_reg <= snap_val;
            // Loads on consecutive cycles still give a single-cycle pulse.
            READY_new_data_to_miso <= snap_load & ~READY_new_data_to_miso;
        end
    end

endmodule

// File: doc/error_count_ctrl.md
ERROR_COUNT_CTRL -- requirements
Module: error_count_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on CHIP_SELECT (legal 2..4).
REQ-002 CLK  input  1  single block clock; all state on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CHIP_SELECT  input  1  SPI frame select, active-low, asynchronous to CLK; rising edge marks a complete command word.
REQ-005 spi_control_reg  input  16  command word from SPI receiver; stable while CHIP_SELECT high; [15:12] opcode, [11:0] argument.
REQ-006 DATA_IN  input  1  received bit under test.
REQ-007 REF_IN  input  1  expected bit, aligned with DATA_IN.
REQ-008 DATA_VALID  input  1  qualifies DATA_IN/REF_IN for one cycle.
REQ-009 ERROR_COUNT_reg  output  16  snapshot of error count, fed to SPI transmitter load port.
REQ-010 READY_new_data_to_miso  output  1  one-cycle pulse after ERROR_COUNT_reg updated.
REQ-011 BUSY  output  1  high while state RUN.
REQ-012 OVERFLOW  output  1  sticky, error count saturated.

Function
REQ-013 CHIP_SELECT shall pass through SYNC_STAGES flops plus one edge-detect flop; command strobe = synchronized rising edge, one cycle wide.
REQ-014 On command strobe spi_control_reg shall be sampled and executed in that same cycle; strobe at cycle N from pin edge latency SYNC_STAGES+1 cycles (±1 for metastability).
REQ-015 Opcodes: 0x1 START, 0x2 STOP, 0x3 CLEAR, 0x4 SNAPSHOT; all other opcodes ignored with no state change.
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE: START -> RUN, error count := 0, OVERFLOW := 0, window := argument; other opcodes per REQ-022..024.
REQ-018 RUN: each DATA_VALID cycle with DATA_IN != REF_IN increments error count by 1; matches and non-valid cycles leave it unchanged.
REQ-019 Error count 16-bit saturating: at 0xFFFF further mismatches hold 0xFFFF and set OVERFLOW; no wrap to 0.
REQ-020 Window nonzero: each DATA_VALID in RUN decrements window; the valid cycle taking window 1->0 is counted, then FSM -> DONE next cycle.
REQ-021 Window argument 0: free-running, RUN exits only on STOP or RESET.
REQ-022 STOP in RUN -> DONE; a mismatch in the STOP cycle is counted; STOP in IDLE ignored.
REQ-023 CLEAR in any state: error count := 0, OVERFLOW := 0, state and window unchanged; a mismatch in the same cycle is discarded (clear wins).
REQ-024 SNAPSHOT in any state: ERROR_COUNT_reg := current count including any mismatch of that cycle; READY pulses next cycle; state unchanged.
REQ-025 DONE (one cycle): ERROR_COUNT_reg := final count; READY pulses in following cycle; FSM -> IDLE; count held until next START/CLEAR.
REQ-026 START in RUN: restart per REQ-017; no READY pulse for aborted run.
REQ-027 Window end and STOP in same cycle: single DONE, single READY pulse.
REQ-028 READY_new_data_to_miso shall never exceed one cycle high; back-to-back snapshots produce separate pulses.
REQ-029 BUSY = 1 exactly when state is RUN.

Reset
REQ-030 RESET high asynchronously forces: state IDLE, error count 0, window 0, ERROR_COUNT_reg 0x0000, READY 0, BUSY 0, OVERFLOW 0, synchronizer and edge flops to 1 (CS idle-high) so RESET release generates no spurious strobe.
REQ-031 RESET mid-RUN shall abort without READY pulse; first command after release executes normally.

Verification
REQ-032 START 0x1010 (window 16), 16 valids with mismatches at bits 3,7,15 -> DONE, ERROR_COUNT_reg=0x0003, one READY pulse, BUSY falls.
REQ-033 START 0x1000, 70000 valid mismatches -> count 0xFFFF, OVERFLOW=1; SNAPSHOT 0x4000 -> ERROR_COUNT_reg=0xFFFF, one READY pulse, BUSY stays 1; STOP -> IDLE.
REQ-034 RUN with count 5, CLEAR coincident with mismatch -> count 0; subsequent 2 mismatches then STOP -> ERROR_COUNT_reg=0x0002.
REQ-035 Opcode 0x7 and STOP while IDLE -> no state change, no READY, outputs unchanged.
REQ-036 Window-1 bit and STOP strobe same cycle -> exactly one READY pulse; RESET asserted mid-RUN -> all outputs 0, no READY, CS glitch-free after release.
